// File: rtl/sort_scheduler.sv
// Sequencer that time-shares one K-word sort memory between host load, the sort
// datapath and host unload, with a sort start pulse and a SORT-phase watchdog.
module sort_scheduler #(
  parameter int unsigned K       = 8,
  parameter int unsigned W       = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          sort_start,
  input  logic          sort_done,
  input  logic [AW-1:0] srt_addr,
  input  logic          srt_we,
  input  logic [W-1:0]  srt_wdata,
  output logic [W-1:0]  srt_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {StLoad, StKick, StSort, StUnload} state_e;

  localparam int unsigned   WdW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] CntLast = AW'(K - 1);
  localparam logic [WdW-1:0] WdLast = (TIMEOUT == 0) ? '0 : WdW'(TIMEOUT - 1);
  localparam logic          WdOn    = (TIMEOUT != 0);

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Memory port mux and handshake outputs
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sort_start = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    unique case (state_q)
      StLoad: begin
        in_ready  = 1'b1;
        mem_addr  = cnt_q;
        mem_we    = in_valid;
        mem_wdata = in_data;
      end
      StKick: sort_start = 1'b1;
      StSort: begin
        mem_addr  = srt_addr;
        mem_we    = srt_we;
        mem_wdata = srt_wdata;
      end
      StUnload: begin
        out_valid = 1'b1;
        mem_addr  = cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StKick;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StKick: begin
        state_d = StSort;
        wdog_d  = '0;
      end
      StSort: begin
        wdog_d = wdog_q + 1'b1;
        // done beats a coincident watchdog expiry
        if (sort_done) begin
          state_d = StUnload;
          cnt_d   = '0;
        end else if (WdOn && wdog_q == WdLast) begin
          err_d   = 1'b1;
          state_d = StUnload;
          cnt_d   = '0;
        end
      end
      StUnload: begin
        if (out_ready) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StLoad;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (srt_we && state_q != StSort) err_d = 1'b1;

    if (abort) begin
      state_d = StLoad;
      cnt_d   = '0;
      wdog_d  = '0;
      err_d   = 1'b0;
    end
  end

  assign out_data  = mem_rdata;
  assign srt_rdata = mem_rdata;
  assign busy      = !(state_q == StLoad && cnt_q == '0);
  assign err       = err_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Bench for sort_scheduler: memory model, a behavioural sorter and a reference of
// each batch's expected result sequence, driven by directed and random steps.
module tb_sort_scheduler;
  localparam int K = 8;

  logic       clk, rst_n, abort, in_valid, in_ready, out_valid, out_ready;
  logic       sort_start, sort_done, srt_we, mem_we, busy, err;
  logic [7:0] in_data, out_data, srt_wdata, srt_rdata, mem_wdata, mem_rdata;
  logic [2:0] srt_addr, mem_addr;

  logic [7:0] mem [K];
  logic [7:0] batch [K];
  logic [7:0] expq [$];
  logic       err_exp;
  int         total, bad;

  sort_scheduler #(.K(8), .W(8), .AW(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sort_start(sort_start), .sort_done(sort_done),
    .srt_addr(srt_addr), .srt_we(srt_we), .srt_wdata(srt_wdata), .srt_rdata(srt_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_batch();
    for (int i = 0; i < K; i++) batch[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic make_sorted();
    expq.delete();
    for (int i = 0; i < K; i++) expq.push_back(batch[i]);
    expq.sort();
  endtask

  // Loads batch[], checks the KICK cycle, returns in the first SORT cycle
  task automatic load_batch(input bit gaps);
    for (int i = 0; i < K; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        #1 chk("load_idle_we", mem_we, 1'b0);
        chk("load_idle_rdy", in_ready, 1'b1);
        tick();
      end
      in_valid = 1'b1;
      in_data  = batch[i];
      #1 chk("load_rdy", in_ready, 1'b1);
      chk("load_we", mem_we, 1'b1);
      chk("load_addr", mem_addr, i);
      chk("load_wdata", mem_wdata, batch[i]);
      chk("load_busy", busy, i != 0);
      chk("load_err", err, err_exp);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("kick_start", sort_start, 1'b1);
    chk("kick_rdy", in_ready, 1'b0);
    chk("kick_we", mem_we, 1'b0);
    chk("kick_addr", mem_addr, 0);
    tick();
    chk("sort_start_once", sort_start, 1'b0);
    for (int i = 0; i < K; i++) chk("load_mem", mem[i], batch[i]);
  endtask

  // Sorter writes expq[] to addr 0..K-1, then raises done in SORT cycle done_at
  task automatic sort_phase(input int done_at);
    for (int c = 0; c <= done_at; c++) begin
      srt_we    = (c < K);
      srt_addr  = 3'(c);
      srt_wdata = (c < K) ? expq[c] : 8'h00;
      sort_done = (c == done_at);
      #1 chk("sort_ovalid", out_valid, 1'b0);
      chk("sort_rdy", in_ready, 1'b0);
      chk("sort_err", err, err_exp);
      chk("sort_we", mem_we, c < K);
      tick();
    end
    srt_we    = 1'b0;
    sort_done = 1'b0;
    chk("done_err", err, err_exp);
    chk("done_ovalid", out_valid, 1'b1);
  endtask

  // n transfers; mode 0 uses out_ready pattern 1,0,1, mode 1 random
  task automatic unload(input int n, input bit mode);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 100) begin
      out_ready = mode ? 1'($urandom_range(0, 1)) : (cyc % 3 != 1);
      #1 chk("unl_valid", out_valid, 1'b1);
      chk("unl_data", out_data, expq[k]);
      chk("unl_err", err, err_exp);
      if (out_ready) k++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    chk("unl_budget", k, n);
    if (n == K) begin
      chk("unl_end_rdy", in_ready, 1'b1);
      chk("unl_end_busy", busy, 1'b0);
      chk("unl_end_ovalid", out_valid, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] saved;
    total = 0; bad = 0; err_exp = 1'b0;
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sort_done = 1'b0; srt_addr = '0; srt_we = 1'b0; srt_wdata = '0;
    #2;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_start", sort_start, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Directed batch, then a sorter write while the host is also offering data
    batch = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    load_batch(1'b0);
    in_valid = 1'b1; in_data = 8'h55;
    srt_addr = 3'd3; srt_we = 1'b1; srt_wdata = 8'hAA;
    #1 chk("srt_we", mem_we, 1'b1);
    chk("srt_addr", mem_addr, 3);
    chk("srt_wdata", mem_wdata, 8'hAA);
    chk("srt_rdy", in_ready, 1'b0);
    tick();
    in_valid = 1'b0; srt_we = 1'b0;
    chk("srt_mem3", mem[3], 8'hAA);
    make_sorted();
    sort_phase(K);
    unload(K, 1'b0);

    // done coinciding with the last watchdog cycle must not flag err
    rand_batch(); make_sorted();
    load_batch(1'b1);
    sort_phase(15);
    unload(K, 1'b1);

    // Watchdog expiry with no done: unsorted data unloads, err sticks
    rand_batch();
    load_batch(1'b0);
    for (int c = 0; c < 16; c++) begin
      #1 chk("wd_ovalid", out_valid, 1'b0);
      chk("wd_err", err, 1'b0);
      tick();
    end
    chk("wd_fired", err, 1'b1);
    chk("wd_unload", out_valid, 1'b1);
    err_exp = 1'b1;
    expq.delete();
    for (int i = 0; i < K; i++) expq.push_back(batch[i]);
    unload(K, 1'b1);
    rand_batch(); make_sorted();
    load_batch(1'b1);
    sort_phase(K);
    unload(K, 1'b0);

    // Abort mid-unload, then a stray sorter write while loading
    rand_batch(); make_sorted();
    load_batch(1'b0);
    sort_phase(K);
    unload(3, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    err_exp = 1'b0;
    chk("abort_rdy", in_ready, 1'b1);
    chk("abort_ovalid", out_valid, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", mem_addr, 0);
    saved = mem[2];
    srt_addr = 3'd2; srt_we = 1'b1; srt_wdata = 8'hEE;
    #1 chk("stray_we", mem_we, 1'b0);
    tick();
    srt_we = 1'b0;
    chk("stray_err", err, 1'b1);
    chk("stray_mem", mem[2], saved);

    // Asynchronous reset in SORT, then fresh back-to-back batches
    rand_batch(); make_sorted();
    err_exp = 1'b1;
    load_batch(1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("arst_rdy", in_ready, 1'b1);
    chk("arst_ovalid", out_valid, 1'b0);
    chk("arst_start", sort_start, 1'b0);
    chk("arst_we", mem_we, 1'b0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    err_exp = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rand_batch(); make_sorted();
      load_batch(1'b1);
      sort_phase(K + int'($urandom_range(0, 5)));
      unload(K, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
